// File: rtl/conv_bram_1d_ctrl.sv
// conv_bram_1d_ctrl
// Sequencer for the 1-D BRAM convolution datapath. A start pulse launches one
// pass over the image row. The controller reads one column per cycle and
// delays the read strobe to match the RAM latency, so the datapath shifts each
// column in as it arrives. It then marks which shifted columns complete a
// filter window on the output stride, tags each such window with its result
// address, and reports completion once the datapath has written the final
// result.
module conv_bram_1d_ctrl #(
    parameter int IMG_W                 = 32,
    parameter int FILTER_L              = 3,
    parameter int STRIDE_W              = 1,
    parameter int RAM_RD_LAT            = 1,
    parameter int RESULT_W              = (IMG_W - FILTER_L) / STRIDE_W + 1,
    parameter int IMG_RAM_ADDR_WIDTH    = $clog2(IMG_W),
    parameter int RESULT_RAM_ADDR_WIDTH = $clog2(RESULT_W)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic [IMG_RAM_ADDR_WIDTH-1:0]    img_rdaddr,
    output logic                             img_rden,
    output logic                             dpath_sr_wren,
    output logic [RESULT_RAM_ADDR_WIDTH-1:0] dpath_result_wraddr,
    output logic                             dpath_result_wren,
    input  logic                             last_val
);

    localparam int IRAW = IMG_RAM_ADDR_WIDTH;
    localparam int RRAW = RESULT_RAM_ADDR_WIDTH;
    // Stride phase needs at least one bit even when every window is kept.
    localparam int PH_W = (STRIDE_W > 1) ? $clog2(STRIDE_W) : 1;

    localparam logic [IRAW-1:0] LAST_COL      = IRAW'(IMG_W - 1);
    localparam logic [IRAW-1:0] FIRST_OUT_COL = IRAW'(FILTER_L - 1);
    localparam logic [PH_W-1:0] PH_MAX        = PH_W'(STRIDE_W - 1);
    localparam logic [RRAW-1:0] WADDR_MAX     = RRAW'(RESULT_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state;

    // Issue-side bookkeeping: phase within the stride, and the result address
    // the next emitting column will carry.
    logic [PH_W-1:0] phase;
    logic [RRAW-1:0] issue_waddr;

    // Classification of the column being read this cycle.
    logic col_in_window;
    logic col_emits;

    // Delay lines aligning read strobe, emit flag and tag with returning data.
    logic [RAM_RD_LAT-1:0] rd_dly;
    logic [RAM_RD_LAT-1:0] emit_dly;
    logic [RRAW-1:0]       waddr_dly [RAM_RD_LAT];

    // Decide whether the column being issued closes a window on the stride grid.
    always_comb begin
        col_in_window = 1'b0;
        col_emits     = 1'b0;
        if (img_rden) begin
            col_in_window = (img_rdaddr >= FIRST_OUT_COL);
            col_emits     = col_in_window && (phase == {PH_W{1'b0}});
        end else begin
            col_in_window = 1'b0;
            col_emits     = 1'b0;
        end
    end

    // Control FSM: column read sequencing, stride phase, busy/done handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            img_rden    <= 1'b0;
            img_rdaddr  <= {IRAW{1'b0}};
            phase       <= {PH_W{1'b0}};
            issue_waddr <= {RRAW{1'b0}};
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        img_rden    <= 1'b1;
                        img_rdaddr  <= {IRAW{1'b0}};
                        phase       <= {PH_W{1'b0}};
                        issue_waddr <= {RRAW{1'b0}};
                    end
                end
                RUN: begin
                    if (img_rdaddr == LAST_COL) begin
                        img_rden <= 1'b0;
                        state    <= WAIT;
                    end else begin
                        img_rdaddr <= img_rdaddr + IRAW'(1);
                    end
                    // Phase only advances once the window is full, so the
                    // first full window is always on the stride grid.
                    if (col_in_window) begin
                        if (phase == PH_MAX) begin
                            phase <= {PH_W{1'b0}};
                        end else begin
                            phase <= phase + PH_W'(1);
                        end
                    end
                    // Saturate rather than wrap: the last result keeps its tag.
                    if (col_emits && (issue_waddr != WADDR_MAX)) begin
                        issue_waddr <= issue_waddr + RRAW'(1);
                    end
                end
                WAIT: begin
                    if (last_val) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    img_rden <= 1'b0;
                end
            endcase
        end
    end

    // Read-latency delay line for the shift strobe, emit flag and result tag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_dly   <= {RAM_RD_LAT{1'b0}};
            emit_dly <= {RAM_RD_LAT{1'b0}};
            for (int i = 0; i < RAM_RD_LAT; i++) begin
                waddr_dly[i] <= {RRAW{1'b0}};
            end
        end else begin
            rd_dly[0]    <= img_rden;
            emit_dly[0]  <= col_emits;
            waddr_dly[0] <= issue_waddr;
            for (int i = 1; i < RAM_RD_LAT; i++) begin
                rd_dly[i]    <= rd_dly[i-1];
                emit_dly[i]  <= emit_dly[i-1];
                waddr_dly[i] <= waddr_dly[i-1];
            end
        end
    end

    // Returning data is shifted in the cycle it arrives.
    assign dpath_sr_wren = rd_dly[RAM_RD_LAT-1];

    // One cycle after the shift the window is complete: launch the result
    // valid and hold the address between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dpath_result_wren   <= 1'b0;
            dpath_result_wraddr <= {RRAW{1'b0}};
        end else begin
            dpath_result_wren <= emit_dly[RAM_RD_LAT-1];
            if (emit_dly[RAM_RD_LAT-1]) begin
                dpath_result_wraddr <= waddr_dly[RAM_RD_LAT-1];
            end
        end
    end

endmodule
